// File: rtl/effect_sample_bridge.sv
// Avalon-MM register bank bridging ADC samples in and a DAC sample FIFO out.
// Define BRIDGE_OUT_SAT_EN to saturate OUTPUT writes to the signed SAMPLE_W range.
module effect_sample_bridge #(
    parameter int SAMPLE_W   = 24,
    parameter int FIFO_DEPTH = 8,
    parameter int GAIN_RST   = 1,
    parameter int BOOST_RST  = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4:0]          avl_address,
    input  logic                avl_read,
    input  logic                avl_write,
    input  logic [31:0]         avl_writedata,
    output logic [31:0]         avl_readdata,
    input  logic                in_valid,
    input  logic [SAMPLE_W-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SAMPLE_W-1:0] out_data
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [4:0] ADDR_GAIN   = 5'd1;
    localparam logic [4:0] ADDR_BOOST  = 5'd2;
    localparam logic [4:0] ADDR_STATUS = 5'd3;
    localparam logic [4:0] ADDR_OUTPUT = 5'd5;
    localparam logic [4:0] ADDR_INPUT  = 5'd6;

    function automatic logic [31:0] sext32(input logic [SAMPLE_W-1:0] v);
        return 32'(signed'(v));
    endfunction

`ifdef BRIDGE_OUT_SAT_EN
    localparam logic signed [31:0] SAT_MAX = (32'sd1 <<< (SAMPLE_W - 1)) - 32'sd1;
    localparam logic signed [31:0] SAT_MIN = -SAT_MAX - 32'sd1;

    function automatic logic [SAMPLE_W-1:0] sat_sample(input logic signed [31:0] v);
        logic signed [31:0] w_clip;
        if (v > SAT_MAX)
            w_clip = SAT_MAX;
        else if (v < SAT_MIN)
            w_clip = SAT_MIN;
        else
            w_clip = v;
        return SAMPLE_W'(w_clip);
    endfunction
`endif

    logic [31:0]         r_readdata;
    logic [31:0]         r_gain;
    logic [31:0]         r_boost;
    logic [SAMPLE_W-1:0] r_shadow;
    logic [SAMPLE_W-1:0] r_sample;
    logic                r_in_avail;
    logic                r_overrun;
    logic                r_drop;
    logic [SAMPLE_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wptr;
    logic [PTR_W-1:0]    r_rptr;
    logic [LVL_W-1:0]    r_level;

    logic                w_rd_input;
    logic                w_wr_status;
    logic                w_wr_output;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_drop_set;
    logic                w_ovr_set;
    logic [SAMPLE_W-1:0] w_push_val;
    logic [31:0]         w_status;
    logic [31:0]         w_rdata;

    assign w_rd_input  = avl_read && (avl_address == ADDR_INPUT);
    assign w_wr_status = avl_write && (avl_address == ADDR_STATUS);
    assign w_wr_output = avl_write && (avl_address == ADDR_OUTPUT);

    assign w_empty    = (r_level == '0);
    assign w_full     = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_pop      = !w_empty && out_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_push     = w_wr_output && (!w_full || w_pop);
    assign w_drop_set = w_wr_output && w_full && !w_pop;
    assign w_ovr_set  = in_valid && r_in_avail && !w_rd_input;

`ifdef BRIDGE_OUT_SAT_EN
    assign w_push_val = sat_sample(signed'(avl_writedata));
`else
    assign w_push_val = avl_writedata[SAMPLE_W-1:0];
`endif

    assign w_status = {16'h0, 8'(r_level), 3'b000, r_drop, r_overrun,
                       w_empty, w_full, r_in_avail};

    always_comb begin
        w_rdata = 32'h0;
        case (avl_address)
            ADDR_GAIN:   w_rdata = r_gain;
            ADDR_BOOST:  w_rdata = r_boost;
            ADDR_STATUS: w_rdata = w_status;
            ADDR_OUTPUT: w_rdata = sext32(r_shadow);
            ADDR_INPUT:  w_rdata = sext32(r_sample);
            default:     w_rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata <= 32'h0;
            r_gain     <= 32'(GAIN_RST);
            r_boost    <= 32'(BOOST_RST);
            r_shadow   <= '0;
            r_sample   <= '0;
            r_in_avail <= 1'b0;
            r_overrun  <= 1'b0;
            r_drop     <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
        end else begin
            if (avl_read)
                r_readdata <= w_rdata;

            if (avl_write && avl_address == ADDR_GAIN)
                r_gain <= avl_writedata;
            if (avl_write && avl_address == ADDR_BOOST)
                r_boost <= avl_writedata;
            if (w_wr_output)
                r_shadow <= w_push_val;

            if (in_valid) begin
                r_sample   <= in_data;
                r_in_avail <= 1'b1;
            end else if (w_rd_input) begin
                r_in_avail <= 1'b0;
            end

            // Hardware set events take priority over software W1C clears.
            if (w_ovr_set)
                r_overrun <= 1'b1;
            else if (w_wr_status && avl_writedata[3])
                r_overrun <= 1'b0;

            if (w_drop_set)
                r_drop <= 1'b1;
            else if (w_wr_status && avl_writedata[4])
                r_drop <= 1'b0;

            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)
                r_level <= r_level + 1'b1;
            else if (!w_push && w_pop)
                r_level <= r_level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= w_push_val;
    end

    assign avl_readdata = r_readdata;
    assign out_valid    = !w_empty;
    assign out_data     = w_empty ? '0 : r_mem[r_rptr];

endmodule

// File: tb/tb_effect_sample_bridge.sv
// Self-checking bench for effect_sample_bridge: directed vectors plus randomized
// traffic compared against a queue-based reference model.
module tb_effect_sample_bridge;

    localparam int SW    = 24;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    avl_address;
    logic          avl_read;
    logic          avl_write;
    logic [31:0]   avl_writedata;
    logic [31:0]   avl_readdata;
    logic          in_valid;
    logic [SW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] out_data;

    effect_sample_bridge #(
        .SAMPLE_W(SW), .FIFO_DEPTH(DEPTH), .GAIN_RST(1), .BOOST_RST(0)
    ) dut (
        .clk(clk), .reset(reset),
        .avl_address(avl_address), .avl_read(avl_read), .avl_write(avl_write),
        .avl_writedata(avl_writedata), .avl_readdata(avl_readdata),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0]   m_gain, m_boost, m_rd;
    logic [SW-1:0] m_shadow, m_sample;
    bit            m_avail, m_ovr, m_drop;
    logic [SW-1:0] m_q[$];

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] exp;
    } rd_vec_t;
    rd_vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sx(input logic [SW-1:0] v);
        return 32'(signed'(v));
    endfunction

    function automatic logic [SW-1:0] out_conv(input logic [31:0] wd);
`ifdef BRIDGE_OUT_SAT_EN
        int v;
        v = signed'(wd);
        if (v > 8388607) return 24'h7FFFFF;
        if (v < -8388608) return 24'h800000;
        return wd[SW-1:0];
`else
        return wd[SW-1:0];
`endif
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = 32'h0;
        s[0] = m_avail;
        s[1] = (m_q.size() == DEPTH);
        s[2] = (m_q.size() == 0);
        s[3] = m_ovr;
        s[4] = m_drop;
        s[15:8] = 8'(m_q.size());
        return s;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd1: return m_gain;
            5'd2: return m_boost;
            5'd3: return m_status();
            5'd5: return sx(m_shadow);
            5'd6: return sx(m_sample);
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_gain = 32'h1; m_boost = 32'h0; m_rd = 32'h0;
        m_shadow = '0; m_sample = '0;
        m_avail = 0; m_ovr = 0; m_drop = 0;
        m_q.delete();
    endtask

    task automatic model_step(input bit rd, input bit wr, input logic [4:0] a,
                              input logic [31:0] wd, input bit iv,
                              input logic [SW-1:0] id, input bit ordy);
        bit pop, rdin, full_now, do_push;
        logic [SW-1:0] v;
        pop      = (m_q.size() > 0) && ordy;
        rdin     = rd && (a == 5'd6);
        full_now = (m_q.size() == DEPTH);
        do_push  = 0;
        v        = '0;
        if (rd) m_rd = m_read(a);
        if (wr) begin
            case (a)
                5'd1: m_gain = wd;
                5'd2: m_boost = wd;
                5'd3: begin
                    if (wd[3]) m_ovr = 0;
                    if (wd[4]) m_drop = 0;
                end
                5'd5: begin
                    v = out_conv(wd);
                    m_shadow = v;
                    if (full_now && !pop) m_drop = 1;
                    else do_push = 1;
                end
                default: ;
            endcase
        end
        if (pop) void'(m_q.pop_front());
        if (do_push) m_q.push_back(v);
        if (iv) begin
            if (m_avail && !rdin) m_ovr = 1;
            m_sample = id;
            m_avail  = 1;
        end else if (rdin) begin
            m_avail = 0;
        end
    endtask

    task automatic step(input bit rd, input bit wr, input logic [4:0] a,
                        input logic [31:0] wd, input bit iv, input logic [SW-1:0] id);
        avl_read = rd; avl_write = wr; avl_address = a; avl_writedata = wd;
        in_valid = iv; in_data = id;
        model_step(rd, wr, a, wd, iv, id, out_ready);
        @(posedge clk);
        #1;
        avl_read = 0; avl_write = 0; in_valid = 0;
        chk("readdata", avl_readdata, m_rd);
        chk("out_valid", {31'h0, out_valid}, {31'h0, (m_q.size() != 0)});
        chk("out_data", {8'h0, out_data}, (m_q.size() != 0) ? {8'h0, m_q[0]} : 32'h0);
    endtask

    task automatic rd(input logic [4:0] a);
        step(1, 0, a, 32'h0, 0, '0);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        step(0, 1, a, d, 0, '0);
    endtask

    task automatic idle();
        step(0, 0, 5'd0, 32'h0, 0, '0);
    endtask

    // Reset asserted between edges so the asynchronous drop of out_valid is observable.
    task automatic do_reset();
        #2;
        reset = 1;
        model_reset();
        #1;
        chk("reset_async_out_valid", {31'h0, out_valid}, 32'h0);
        chk("reset_async_out_data", {8'h0, out_data}, 32'h0);
        @(posedge clk);
        #1;
        reset = 0;
        chk("reset_readdata", avl_readdata, 32'h0);
    endtask

    initial begin
        logic [SW-1:0] last;
        logic [SW-1:0] e1, e2;
        logic [4:0] addr_pick[10];

        reset = 1; avl_address = 0; avl_read = 0; avl_write = 0; avl_writedata = 0;
        in_valid = 0; in_data = 0; out_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 0;

        tbl[0] = '{5'd1, 32'h1};
        tbl[1] = '{5'd2, 32'h0};
        tbl[2] = '{5'd3, 32'h4};
        tbl[3] = '{5'd4, 32'h0};
        tbl[4] = '{5'd5, 32'h0};
        tbl[5] = '{5'd6, 32'h0};
        tbl[6] = '{5'd0, 32'h0};
        for (int i = 0; i < 7; i++) begin
            rd(tbl[i].addr);
            chk($sformatf("reset_read_a%0d", tbl[i].addr), avl_readdata, tbl[i].exp);
        end
        chk("reset_out_valid", {31'h0, out_valid}, 32'h0);

        // Input capture and sign extension
        step(0, 0, 5'd0, 32'h0, 1, 24'h800010);
        rd(5'd6);
        chk("input_sext", avl_readdata, 32'hFF800010);
        rd(5'd3);
        chk("in_avail_cleared", {31'h0, avl_readdata[0]}, 32'h0);

        // Overrun and W1C
        step(0, 0, 5'd0, 32'h0, 1, 24'h000123);
        step(0, 0, 5'd0, 32'h0, 1, 24'h000456);
        rd(5'd3);
        chk("status_overrun", avl_readdata, 32'h0000000D);
        wr(5'd3, 32'h8);
        rd(5'd3);
        chk("status_w1c", avl_readdata, 32'h00000005);

        // INPUT read concurrent with in_valid: old data returned, no overrun
        step(1, 0, 5'd6, 32'h0, 1, 24'h0ABCDE);
        chk("rd_with_iv_old", avl_readdata, 32'h00000456);
        rd(5'd3);
        chk("rd_with_iv_status", avl_readdata, 32'h00000005);
        rd(5'd6);

        // Fill, drop, drain in order
        out_ready = 0;
        for (int k = 1; k <= 9; k++) wr(5'd5, k);
        rd(5'd3);
        chk("status_full_drop", avl_readdata, 32'h00000812);
        out_ready = 1;
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("drain_%0d", k), {8'h0, out_data}, k);
            idle();
        end
        chk("drained_out_valid", {31'h0, out_valid}, 32'h0);
        rd(5'd3);
        chk("status_after_drain", avl_readdata, 32'h00000014);
        wr(5'd3, 32'h10);

        // Push into full FIFO with simultaneous pop
        out_ready = 0;
        for (int k = 0; k < 8; k++) wr(5'd5, 32'h10 + k);
        out_ready = 1;
        wr(5'd5, 32'h55);
        out_ready = 0;
        rd(5'd3);
        chk("full_push_pop_status", avl_readdata, 32'h00000802);
        out_ready = 1;
        last = '0;
        for (int k = 0; k < 8; k++) begin
            last = out_data;
            idle();
        end
        chk("push_pop_last", {8'h0, last}, 32'h55);

        // OUTPUT conversion at the extremes
`ifdef BRIDGE_OUT_SAT_EN
        e1 = 24'h7FFFFF; e2 = 24'h800000;
`else
        e1 = 24'hFFFFFF; e2 = 24'h000000;
`endif
        out_ready = 0;
        wr(5'd5, 32'h7FFFFFFF);
        chk("conv_pos", {8'h0, out_data}, {8'h0, e1});
        out_ready = 1;
        idle();
        out_ready = 0;
        wr(5'd5, 32'h80000000);
        chk("conv_neg", {8'h0, out_data}, {8'h0, e2});
        rd(5'd5);
        chk("shadow_read", avl_readdata, sx(e2));
        out_ready = 1;
        idle();

        // Randomized traffic against the model
        addr_pick = '{5'd1, 5'd2, 5'd3, 5'd5, 5'd6, 5'd0, 5'd4, 5'd5, 5'd5, 5'd3};
        for (int n = 0; n < 2000; n++) begin
            bit r_b, w_b, iv_b;
            logic [4:0] a;
            logic [31:0] d;
            out_ready = ($urandom_range(0, 2) != 0) ? ((n / 200) % 2 == 0) : $urandom_range(0, 1) == 1;
            r_b  = ($urandom_range(0, 2) == 0);
            w_b  = ($urandom_range(0, 1) == 0);
            iv_b = ($urandom_range(0, 3) == 0);
            a    = addr_pick[$urandom_range(0, 9)];
            d    = $urandom;
            if ($urandom_range(0, 3) == 0) d = {$urandom_range(0, 1) == 1 ? 8'hFF : 8'h00, 24'(d)};
            step(r_b, w_b, a, d, iv_b, SW'($urandom));
        end

        // Reset in the middle of a full FIFO with flags set
        out_ready = 0;
        for (int k = 0; k < 10; k++) wr(5'd5, 32'h100 + k);
        step(0, 0, 5'd0, 32'h0, 1, 24'h1);
        step(0, 0, 5'd0, 32'h0, 1, 24'h2);
        do_reset();
        rd(5'd3);
        chk("status_after_midreset", avl_readdata, 32'h00000004);
        rd(5'd1);
        chk("gain_after_midreset", avl_readdata, 32'h00000001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/effect_sample_bridge.md
Name: effect_sample_bridge

Overview:
Avalon-MM slave register bank that guitar_effect masters for all its register accesses. Captures incoming ADC samples into the INPUT register and holds effect parameters (GAIN, BOOST). Reports status, and pushes samples written to OUTPUT into a FIFO that drains to a valid/ready stream toward the DAC serializer. guitar_effect sits downstream of this block on the input path and upstream of it on the output path.

Parameters:
SAMPLE_W, 24, width of audio samples on both streams
FIFO_DEPTH, 8, output FIFO depth; power of two, 2..128
GAIN_RST, 1, reset value of the GAIN register
BOOST_RST, 0, reset value of the BOOST register

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
avl_address  in  5  word address
avl_read  in  1  read strobe
avl_write  in  1  write strobe
avl_writedata  in  32  write data
avl_readdata  out  32  read data, registered
in_valid  in  1  one-cycle strobe: new ADC sample on in_data
in_data  in  SAMPLE_W  signed ADC sample
out_valid  out  1  output FIFO not empty
out_ready  in  1  consumer accepts out_data
out_data  out  SAMPLE_W  FIFO head sample

Behaviour:
- Reset (async, active-high): avl_readdata=0; out_valid=0; out_data=0; FIFO empty; GAIN=GAIN_RST; BOOST=BOOST_RST; held sample=0; all status flags 0.
- Register map (word addresses):
  - 1 GAIN: R/W, 32 bits.
  - 2 BOOST: R/W, 32 bits.
  - 3 STATUS: read-only except W1C bits.
    - bit0 in_avail; bit1 out_full; bit2 out_empty.
    - bit3 overrun (sticky, W1C); bit4 drop (sticky, W1C).
    - bits[15:8] FIFO level; all other bits 0.
  - 5 OUTPUT: write pushes writedata[SAMPLE_W-1:0] into the FIFO. Read returns the last value written, sign-extended.
  - 6 INPUT: read returns the held sample, sign-extended to 32 bits, and clears in_avail.
  - All other addresses: read 0, write ignored.
- Read latency: exactly 1 cycle. avl_readdata updates on the clock edge following the avl_read cycle and holds until the next read. No waitrequest.
- Read side effects (INPUT clear) take place on the avl_read cycle.
- avl_read and avl_write in the same cycle: the write takes effect, and readdata returns the pre-write value.
- Input capture: in_valid is never back-pressured.
  - If in_avail=0: latch in_data and set in_avail.
  - If in_avail=1: overwrite the held sample and set overrun.
- in_valid in the same cycle as an INPUT read: readdata returns the old sample, the new sample is latched, in_avail stays 1, and overrun is not set.
- in_valid in the same cycle as a W1C write of bit3: the set wins.
- FIFO behaviour:
  - out_valid = !empty; out_data = head; pop on out_valid && out_ready.
  - A push while full is dropped, the drop flag is set, and the level is unchanged.
  - Push while full with a simultaneous pop: the push is accepted and the level stays FIFO_DEPTH.
  - Push while empty: out_valid rises the next cycle. There is no same-cycle fall-through.
  - Pointers wrap modulo FIFO_DEPTH. Level ranges 0..FIFO_DEPTH.
- The OUTPUT shadow register updates on every OUTPUT write, including dropped writes.
- Reset mid-operation: FIFO contents and flags are discarded immediately. out_valid falls asynchronously.

Optional Feature:
BRIDGE_OUT_SAT_EN
- Defined: OUTPUT writedata is treated as signed 32-bit and saturated to the signed SAMPLE_W range before the push; the shadow register stores the saturated value.
- Undefined: the low SAMPLE_W bits are truncated with no saturation.

Test Plan:
- Reset, then read addresses 1, 2, 3, 4 -> readdata 0x1, 0x0, 0x4, 0x0 each one cycle after its read; out_valid=0.
- in_valid with in_data=24'h800010, then read INPUT -> 0xFF800010. Next STATUS read -> bit0=0.
- Two in_valid pulses with no read between them -> STATUS=0x0000000D. Write STATUS 0x8 -> STATUS=0x5.
- out_ready=0; write OUTPUT 1..9 -> STATUS=0x00000812 (level 8, full, drop). Then out_ready=1 -> out_data 1..8 in order, then out_valid=0 and STATUS=0x14.
- FIFO full with out_ready=1 and an OUTPUT write of 0x55 in the same cycle -> push accepted, level stays 8, no drop; 0x55 emerges last.
- Write OUTPUT 0x7FFFFFFF -> out_data 24'h7FFFFF with BRIDGE_OUT_SAT_EN, 24'hFFFFFF without. Write 0x80000000 -> 24'h800000 with the macro, 24'h000000 without.
